// File: rtl/ucode_pkg.sv
// Shared constants for the micro-op sequencer: macro table, default micro-ROM image,
// instruction field positions and the operand patch helper.
package ucode_pkg;

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_RELEASE} state_e;

  localparam int          UROM_MAX = 64;
  localparam logic [6:0]  NOP_OPC  = 7'b1100100;
  localparam logic [3:0]  FIELD_PH = 4'hF;
  localparam int          RD_LSB   = 21;
  localparam int          RS1_LSB  = 17;
  localparam int          RS2_LSB  = 13;

  // Entry [0] is the least significant element of each packed table.
  localparam logic [3:0][6:0] MACRO_OPC   = {7'h73, 7'h72, 7'h71, 7'h70};
  localparam logic [3:0][5:0] MACRO_ENTRY = {6'd12, 6'd10, 6'd30, 6'd4};
  localparam logic [3:0][3:0] MACRO_LEN   = {4'd8,  4'd1,  4'd4,  4'd3};

  typedef logic [UROM_MAX-1:0][31:0] urom_t;

  // Default image: rd/rs1 fields always 4'hF, rs2 field 4'hF on odd words only,
  // address tag in [12:8] so every word is distinguishable.
  function automatic urom_t gen_urom();
    urom_t r;
    for (int i = 0; i < UROM_MAX; i++)
      r[i] = {7'h30, FIELD_PH, FIELD_PH, (i[0] ? FIELD_PH : 4'h2), 5'(i), 8'h00};
    return r;
  endfunction

  localparam urom_t UROM_INIT = gen_urom();

  function automatic logic [31:0] patch(input logic [31:0] w, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [3:0] rs2);
    logic [31:0] p;
    p = w;
    if (w[RD_LSB +: 4]  == FIELD_PH) p[RD_LSB +: 4]  = rd;
    if (w[RS1_LSB +: 4] == FIELD_PH) p[RS1_LSB +: 4] = rs1;
    if (w[RS2_LSB +: 4] == FIELD_PH) p[RS2_LSB +: 4] = rs2;
    return p;
  endfunction

endpackage

// File: rtl/ucode_rom.sv
// Micro-ROM with asynchronous read. With UCODE_WRITABLE_EN defined it becomes a
// flop array reloaded from the package image on reset and written synchronously.
module ucode_rom
  import ucode_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
`ifdef UCODE_WRITABLE_EN
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
`endif
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

`ifdef UCODE_WRITABLE_EN
  logic [DEPTH-1:0][31:0] mem;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= UROM_INIT[i];
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
`else
  assign rdata = UROM_INIT[6'(raddr)];
`endif

endmodule

// File: rtl/ucode_sequencer.sv
// Expands macro-opcodes into micro-op sequences between fetch and decode, holding
// fetch frozen via control. Optional UCODE_WRITABLE_EN adds micro-ROM write ports.
module ucode_sequencer
  import ucode_pkg::*;
#(
  parameter int          UROM_DEPTH = 32,
  parameter int          UADDR_W    = 5,
  parameter logic [31:0] NOP_WORD   = 32'hC800_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        instruction,
  input  logic               flush,
`ifdef UCODE_WRITABLE_EN
  input  logic               urom_we,
  input  logic [UADDR_W-1:0] urom_waddr,
  input  logic [31:0]        urom_wdata,
`endif
  output logic               control,
  output logic [31:0]        instr_out,
  output logic               uop_active,
  output logic               busy
);

  state_e             state;
  logic [UADDR_W-1:0] upc, raddr;
  logic [3:0]         cnt, rd_q, rs1_q, rs2_q;
  logic               hit, start;
  logic [1:0]         hit_idx;
  logic [5:0]         entry;
  logic [3:0]         len;
  logic [31:0]        rom_word;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < 4; i++)
      if (instruction[31:25] == MACRO_OPC[i]) begin
        hit     = 1'b1;
        hit_idx = 2'(i);
      end
  end

  assign entry = MACRO_ENTRY[hit_idx];
  assign len   = MACRO_LEN[hit_idx];
  // Only S_IDLE may start, so the re-presented macro in S_RELEASE is never re-expanded.
  assign start = rst && (state == S_IDLE) && hit && !flush;
  assign raddr = (state == S_IDLE) ? UADDR_W'(entry) : upc;

  ucode_rom #(.DEPTH(UROM_DEPTH), .AW(UADDR_W)) u_rom (
`ifdef UCODE_WRITABLE_EN
    .clk   (clk),
    .rst   (rst),
    .we    (urom_we && rst && (state == S_IDLE) && !start),
    .waddr (urom_waddr),
    .wdata (urom_wdata),
`endif
    .raddr (raddr),
    .rdata (rom_word)
  );

  always_comb begin
    control    = 1'b0;
    instr_out  = instruction;
    uop_active = 1'b0;
    busy       = 1'b0;
    if (rst) begin
      busy = (state != S_IDLE);
      case (state)
        S_IDLE: if (start) begin
          // Operands are not latched yet on the first micro-op, take them straight from the macro.
          instr_out  = patch(rom_word, instruction[RD_LSB +: 4], instruction[RS1_LSB +: 4],
                             instruction[RS2_LSB +: 4]);
          uop_active = 1'b1;
          control    = (len != 4'd1);
        end
        S_EXPAND: begin
          instr_out  = patch(rom_word, rd_q, rs1_q, rs2_q);
          uop_active = 1'b1;
          control    = (cnt != 4'd1);
        end
        S_RELEASE: begin
          instr_out  = NOP_WORD;
          uop_active = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      upc   <= '0;
      cnt   <= '0;
      rd_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (start && len != 4'd1) begin
          rd_q  <= instruction[RD_LSB +: 4];
          rs1_q <= instruction[RS1_LSB +: 4];
          rs2_q <= instruction[RS2_LSB +: 4];
          upc   <= raddr + 1'b1;
          cnt   <= len - 1'b1;
          state <= S_EXPAND;
        end
        S_EXPAND: begin
          upc <= upc + 1'b1;
          cnt <= cnt - 1'b1;
          if (cnt == 4'd1) state <= S_RELEASE;
        end
        S_RELEASE: state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ucode_sequencer.sv
// Directed bench for ucode_sequencer; the writable micro-ROM steps run only with
// UCODE_WRITABLE_EN defined.
module tb_ucode_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] instruction = 32'h0;
  logic        control, uop_active, busy;
  logic [31:0] instr_out;
`ifdef UCODE_WRITABLE_EN
  logic        urom_we = 1'b0;
  logic [4:0]  urom_waddr = 5'd0;
  logic [31:0] urom_wdata = 32'h0;
`endif

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] PLAIN = 32'h1234_5678;
  localparam logic [31:0] NOP   = 32'hC800_0000;

  always #5 clk = ~clk;

  ucode_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .flush       (flush),
`ifdef UCODE_WRITABLE_EN
    .urom_we     (urom_we),
    .urom_waddr  (urom_waddr),
    .urom_wdata  (urom_wdata),
`endif
    .control     (control),
    .instr_out   (instr_out),
    .uop_active  (uop_active),
    .busy        (busy)
  );

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [3:0] rd,
                                     input logic [3:0] rs1, input logic [3:0] rs2);
    return {opc, rd, rs1, rs2, 13'h0};
  endfunction

  // Expected decode word: fields already resolved by hand, address tag from the ROM image.
  function automatic logic [31:0] uw(input logic [3:0] rd, input logic [3:0] rs1,
                                     input logic [3:0] rs2, input int addr);
    return {7'h30, rd, rs1, rs2, 5'(addr), 8'h00};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [31:0] e_out, input logic e_ctl,
                      input logic e_uop, input logic e_busy);
    @(negedge clk);
    chk({tag, ".instr_out"}, instr_out, e_out);
    chk({tag, ".control"}, {31'h0, control}, {31'h0, e_ctl});
    chk({tag, ".uop_active"}, {31'h0, uop_active}, {31'h0, e_uop});
    chk({tag, ".busy"}, {31'h0, busy}, {31'h0, e_busy});
    @(posedge clk);
    #1;
  endtask

  logic [31:0] m0, m1, m2;

  initial begin
    m0 = mk(7'h70, 4'h3, 4'h5, 4'h6);
    m1 = mk(7'h71, 4'h1, 4'h2, 4'h3);
    m2 = mk(7'h72, 4'h7, 4'h8, 4'h9);

    // reset: pass-through even for a macro opcode
    instruction = PLAIN;  step("rst_plain", PLAIN, 1'b0, 1'b0, 1'b0);
    instruction = m0;     step("rst_macro", m0, 1'b0, 1'b0, 1'b0);

    rst = 1'b1;
    instruction = PLAIN;
    step("idle0", PLAIN, 1'b0, 1'b0, 1'b0);
    step("idle1", PLAIN, 1'b0, 1'b0, 1'b0);
    step("idle2", PLAIN, 1'b0, 1'b0, 1'b0);

    // macro 0: ENTRY 4, LEN 3; fetch keeps re-presenting the macro
    instruction = m0;
    step("m0_u0", uw(4'h3, 4'h5, 4'h2, 4), 1'b1, 1'b1, 1'b0);
    step("m0_u1", uw(4'h3, 4'h5, 4'h6, 5), 1'b1, 1'b1, 1'b1);
    step("m0_u2", uw(4'h3, 4'h5, 4'h2, 6), 1'b0, 1'b1, 1'b1);
    step("m0_nop", NOP, 1'b0, 1'b1, 1'b1);
    instruction = PLAIN;
    step("m0_done", PLAIN, 1'b0, 1'b0, 1'b0);

    // flush blocks a start
    instruction = m0; flush = 1'b1;
    step("flush", m0, 1'b0, 1'b0, 1'b0);
    instruction = PLAIN; flush = 1'b0;
    step("flush_idle", PLAIN, 1'b0, 1'b0, 1'b0);

    // macro 1: ENTRY 30, LEN 4 wraps through address 0
    instruction = m1;
    step("m1_a30", uw(4'h1, 4'h2, 4'h2, 30), 1'b1, 1'b1, 1'b0);
    step("m1_a31", uw(4'h1, 4'h2, 4'h3, 31), 1'b1, 1'b1, 1'b1);
    step("m1_a0",  uw(4'h1, 4'h2, 4'h2, 0),  1'b1, 1'b1, 1'b1);
    step("m1_a1",  uw(4'h1, 4'h2, 4'h3, 1),  1'b0, 1'b1, 1'b1);
    step("m1_nop", NOP, 1'b0, 1'b1, 1'b1);
    instruction = PLAIN;
    step("m1_done", PLAIN, 1'b0, 1'b0, 1'b0);

    // macro 2: LEN 1, no freeze
    instruction = m2;
    step("m2_u0", uw(4'h7, 4'h8, 4'h2, 10), 1'b0, 1'b1, 1'b0);
    instruction = PLAIN;
    step("m2_done", PLAIN, 1'b0, 1'b0, 1'b0);

    // flush ignored once expanding
    instruction = m0;
    step("fx_u0", uw(4'h3, 4'h5, 4'h2, 4), 1'b1, 1'b1, 1'b0);
    flush = 1'b1;
    step("fx_u1", uw(4'h3, 4'h5, 4'h6, 5), 1'b1, 1'b1, 1'b1);
    step("fx_u2", uw(4'h3, 4'h5, 4'h2, 6), 1'b0, 1'b1, 1'b1);
    step("fx_nop", NOP, 1'b0, 1'b1, 1'b1);
    flush = 1'b0; instruction = PLAIN;
    step("fx_done", PLAIN, 1'b0, 1'b0, 1'b0);

    // reset on the second micro-op
    instruction = m0;
    step("rm_u0", uw(4'h3, 4'h5, 4'h2, 4), 1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    step("rm_rst", m0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1; instruction = 32'hABCD_0123;
    step("rm_idle", 32'hABCD_0123, 1'b0, 1'b0, 1'b0);
    instruction = m0;
    step("rm_r0", uw(4'h3, 4'h5, 4'h2, 4), 1'b1, 1'b1, 1'b0);
    step("rm_r1", uw(4'h3, 4'h5, 4'h6, 5), 1'b1, 1'b1, 1'b1);
    step("rm_r2", uw(4'h3, 4'h5, 4'h2, 6), 1'b0, 1'b1, 1'b1);
    step("rm_nop", NOP, 1'b0, 1'b1, 1'b1);
    instruction = PLAIN;
    step("rm_done", PLAIN, 1'b0, 1'b0, 1'b0);

`ifdef UCODE_WRITABLE_EN
    // idle write lands; write during a sequence is dropped
    urom_we = 1'b1; urom_waddr = 5'd4; urom_wdata = 32'hDEAD_BEEF;
    step("wr_idle", PLAIN, 1'b0, 1'b0, 1'b0);
    urom_we = 1'b0; instruction = m0;
    step("wr_u0", 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0);
    urom_we = 1'b1; urom_waddr = 5'd5; urom_wdata = 32'h1111_1111;
    step("wr_u1", uw(4'h3, 4'h5, 4'h6, 5), 1'b1, 1'b1, 1'b1);
    urom_we = 1'b0;
    step("wr_u2", uw(4'h3, 4'h5, 4'h2, 6), 1'b0, 1'b1, 1'b1);
    step("wr_nop", NOP, 1'b0, 1'b1, 1'b1);
    instruction = PLAIN;
    step("wr_idle2", PLAIN, 1'b0, 1'b0, 1'b0);
    instruction = m0;
    step("wr2_u0", 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0);
    step("wr2_u1", uw(4'h3, 4'h5, 4'h6, 5), 1'b1, 1'b1, 1'b1);
    step("wr2_u2", uw(4'h3, 4'h5, 4'h2, 6), 1'b0, 1'b1, 1'b1);
    step("wr2_nop", NOP, 1'b0, 1'b1, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
